mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-requester arbiter and sequencer for the single-port program/data memory.
//  Requester LD is the program loader (preload and debug dump); requester CPU is the fetcher/decoder path.
//  It replaces the ad-hoc mux on addr/din/we in front of mem and issues a one-cycle prog_start once a load completes.
//  Sits between the requesters and the mem instance; shares mem's clock.
// PARAMETERS
//  ADDR_WIDTH  `ADDR_WIDTH (16)  memory address width
//  DATA_WIDTH  `REG_WIDTH (8)    memory data width
//  MAX_BURST   8                 max consecutive grants to one owner while the other requests (>=1)
// PORTS
//  clk         in   1           the single clock; all state updates on rising edge
//  reset       in   1           asynchronous, active-high reset
//  ld_req      in   1           loader requests access; held until its transfers are done
//  ld_we       in   1           1=write, 0=read (sampled when granted)
//  ld_addr     in   ADDR_WIDTH  loader address
//  ld_wdata    in   DATA_WIDTH  loader write data
//  ld_gnt      out  1           loader transfer accepted this cycle
//  ld_rvalid   out  1           rdata valid for loader's read from previous cycle
//  cpu_req     in   1           fetcher/decoder requests access
//  cpu_we      in   1           1=write, 0=read
//  cpu_addr    in   ADDR_WIDTH  CPU address
//  cpu_wdata   in   DATA_WIDTH  CPU write data
//  cpu_gnt     out  1           CPU transfer accepted this cycle
//  cpu_rvalid  out  1           rdata valid for CPU's read from previous cycle
//  mem_we      out  1           to mem.we
//  mem_addr    out  ADDR_WIDTH  to mem.addr
//  mem_din     out  DATA_WIDTH  to mem.din
//  mem_dout    in   DATA_WIDTH  from mem.dout (synchronous read, 1-cycle latency)
//  rdata       out  DATA_WIDTH  = mem_dout (pass-through; qualify with *_rvalid)
//  prog_start  out  1           1-cycle pulse: loader finished a tenure that contained >=1 write
// BEHAVIOUR
//  - Reset (async, asserted): state=IDLE, burst_cnt=0, dirty=0.
//    All outputs 0: gnts, rvalids, prog_start, mem_we, mem_addr, mem_din.
//    Reset mid-transfer drops any pending rvalid; no write completes in a cycle in which reset is high.
//  - Owner register states (encodings in pkg): ARB_IDLE, ARB_LD, ARB_CPU. Transitions at clk edge:
//    IDLE: ld_req -> LD; else cpu_req -> CPU; else stay. LD wins a tie.
//    LD: !ld_req -> (cpu_req ? CPU : IDLE); ld_req & cpu_req & burst_cnt==MAX_BURST-1 -> CPU; else stay.
//    CPU: symmetric; !cpu_req -> (ld_req ? LD : IDLE); pre-empted to LD at burst_cnt==MAX_BURST-1 if ld_req.
//  - burst_cnt: counts granted cycles of the current owner; cleared on any owner change.
//    Saturates at MAX_BURST-1 while the other side is idle.
//  - Grant is combinational from the owner register: ld_gnt = (state==LD)&ld_req; cpu_gnt likewise.
//    A granted cycle is exactly one transfer. The requester must hold addr/we/wdata stable while req=1 and gnt=0.
//  - mem_addr/mem_din follow the owner's inputs. mem_we = gnt & owner_we.
//    When no transfer happens, mem_we=0 and mem_addr/mem_din=0.
//  - Read latency 1: x_rvalid registered high the cycle after a granted read by x (x_we=0).
//    Back-to-back reads give continuous rvalid. A switch of owner never misroutes rvalid.
//  - dirty set on any granted LD write. Cleared when prog_start fires.
//    prog_start is registered: pulses the cycle after state leaves LD because ld_req fell, if dirty.
//    Pre-emption does not fire prog_start; dirty is retained.
//  - No combinational path req->gnt across owners; CPU is never starved beyond MAX_BURST LD grants.
// STRUCTURE
//  - pkg.v gains ARB_STATE_WIDTH (2), ARB_IDLE=2'd0, ARB_LD=2'd1, ARB_CPU=2'd2, and default ARB_MAX_BURST=8.
//  - Single flat module; no sub-module. Burst counter width = $clog2(MAX_BURST)+1.
// TESTING
//  1 Reset: assert reset with ld_req=cpu_req=1 -> all outputs 0. Release -> next edge state=LD, ld_gnt=1.
//  2 Loader writes 0x00..0x3F (addr=i, data=i^8'hA5), then reads them back.
//    -> each read returns data=i^8'hA5 with ld_rvalid 1 cycle later. prog_start pulses once after ld_req drops.
//  3 Contention with MAX_BURST=8: both req held -> grants alternate 8 LD / 8 CPU.
//    No cycle has both gnts; CPU's first gnt arrives within 8 cycles.
//  4 CPU read 0x0200 in the same cycle ld_req rises -> CPU gets cpu_rvalid with correct data.
//    LD gnt starts the next cycle; ld_rvalid stays 0.
//  5 Reset asserted mid LD burst (after 3 writes) -> mem_we drops immediately, no prog_start.
//    Writes 0..2 persist, write 3 does not.
//  6 Loader tenure with reads only, then ld_req drops -> prog_start stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: owner-state encodings and defaults.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_STATE_WIDTH = 2;

  localparam logic [ARB_STATE_WIDTH-1:0] ARB_IDLE = 2'd0;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_LD   = 2'd1;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_CPU  = 2'd2;

  localparam int unsigned ARB_MAX_BURST = 8;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    StIdle = ARB_IDLE,
    StLd   = ARB_LD,
    StCpu  = ARB_CPU
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single-port program/data memory.
// The owner register picks loader (LD) or CPU; the owner's request is granted combinationally.
// Bursts are capped at MAX_BURST grants while the other side waits. A finished loader
// tenure that wrote anything raises a one-cycle prog_start.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = ARB_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  prog_start
);

  localparam int unsigned         CntWidth = $clog2(MAX_BURST) + 1;
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MAX_BURST - 1);

  arb_state_e          state_q, state_d;
  logic [CntWidth-1:0] burst_cnt_q, burst_cnt_d;
  logic                dirty_q, dirty_d;
  logic                ld_rvalid_q, cpu_rvalid_q;
  logic                prog_start_q, prog_start_d;
  logic                burst_done;
  logic                ld_done;

  // Grants come only from the registered owner, so there is no req->gnt path across owners.
  always_comb begin
    ld_gnt  = (state_q == StLd) & ld_req;
    cpu_gnt = (state_q == StCpu) & cpu_req;
  end

  // Memory-side mux: drive the granted owner's transfer, otherwise park at zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (ld_gnt) begin
      mem_we   = ld_we;
      mem_addr = ld_addr;
      mem_din  = ld_wdata;
    end else if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end
  end

  // Owner next-state, burst counter and loader-completion bookkeeping.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    burst_done  = (burst_cnt_q == CntMax);
    // Loader tenure ends by its own choice (not by pre-emption).
    ld_done     = (state_q == StLd) & ~ld_req;

    case (state_q)
      StIdle: begin
        if (ld_req) begin
          state_d = StLd;
        end else if (cpu_req) begin
          state_d = StCpu;
        end
      end
      StLd: begin
        if (!ld_req) begin
          state_d = cpu_req ? StCpu : StIdle;
        end else if (cpu_req && burst_done) begin
          state_d = StCpu;
        end
      end
      StCpu: begin
        if (!cpu_req) begin
          state_d = ld_req ? StLd : StIdle;
        end else if (ld_req && burst_done) begin
          state_d = StLd;
        end
      end
      default: state_d = StIdle;
    endcase

    // Count granted cycles; hold at the cap while the other side is quiet.
    if (state_d != state_q) begin
      burst_cnt_d = '0;
    end else if ((ld_gnt || cpu_gnt) && !burst_done) begin
      burst_cnt_d = burst_cnt_q + CntWidth'(1);
    end

    prog_start_d = ld_done & dirty_q;
    dirty_d      = (dirty_q & ~prog_start_d) | (ld_gnt & ld_we);
  end

  // State registers; async reset drops owner, so grants and mem_we fall immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      burst_cnt_q  <= '0;
      dirty_q      <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      prog_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      dirty_q      <= dirty_d;
      ld_rvalid_q  <= ld_gnt & ~ld_we;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      prog_start_q <= prog_start_d;
    end
  end

  // Registered qualifiers and memory read-data pass-through.
  always_comb begin
    ld_rvalid  = ld_rvalid_q;
    cpu_rvalid = cpu_rvalid_q;
    prog_start = prog_start_q;
    rdata      = mem_dout;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected read data on each granted
// read, a negedge monitor pops on rvalid. Inputs change at posedge+1, outputs sampled at negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, ld_we, cpu_req, cpu_we;
  logic [15:0] ld_addr, cpu_addr, mem_addr;
  logic [7:0]  ld_wdata, cpu_wdata, mem_din, mem_dout, rdata;
  logic        ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, mem_we, prog_start;

  logic [7:0]  mem [0:65535];
  logic [7:0]  ld_q[$];
  logic [7:0]  cpu_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ps_count = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .MAX_BURST (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .rdata     (rdata),
    .prog_start(prog_start)
  );

  // Synchronous single-port memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: rvalid pops scoreboard, grant exclusivity, prog_start pulse counting.
  initial begin
    logic [7:0] exp_d;
    forever begin
      @(negedge clk);
      if (prog_start) ps_count++;
      check_eq("gnt_exclusive", {31'd0, ld_gnt & cpu_gnt}, 32'd0);
      if (ld_rvalid) begin
        if (ld_q.size() == 0) check_eq("ld_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          exp_d = ld_q.pop_front();
          check_eq("ld_rdata", {24'd0, rdata}, {24'd0, exp_d});
        end
      end
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) check_eq("cpu_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          exp_d = cpu_q.pop_front();
          check_eq("cpu_rdata", {24'd0, rdata}, {24'd0, exp_d});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One loader transfer; returns at posedge+1 after the granted edge with req still high.
  task automatic ld_xfer(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd, output int waited);
    bit done;
    ld_req   = 1'b1;
    ld_we    = we;
    ld_addr  = addr;
    ld_wdata = wd;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ld_gnt) begin
        if (!we) ld_q.push_back(exp_rd);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 64) begin
          check_eq("ld_gnt_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ld_release();
    ld_req   = 1'b0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_wdata = '0;
  endtask

  initial begin
    int w;
    int ps0;
    bit exp_ld, exp_cpu;

    // Test 1: reset with both requesting.
    reset     = 1'b1;
    ld_req    = 1'b1;
    ld_we     = 1'b1;
    ld_addr   = 16'h0000;
    ld_wdata  = 8'hA5;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0006;
    cpu_wdata = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t1_rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    check_eq("t1_rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check_eq("t1_rst_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
    check_eq("t1_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check_eq("t1_rst_prog_start", {31'd0, prog_start}, 32'd0);
    check_eq("t1_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("t1_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("t1_rst_mem_din", {24'd0, mem_din}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t1_idle_before_edge", {31'd0, ld_gnt}, 32'd0);
    @(negedge clk);
    check_eq("t1_ld_gnt_after_edge", {31'd0, ld_gnt}, 32'd1);
    check_eq("t1_cpu_gnt_after_edge", {31'd0, cpu_gnt}, 32'd0);
    check_eq("t1_mem_we", {31'd0, mem_we}, 32'd1);
    check_eq("t1_mem_din", {24'd0, mem_din}, 32'hA5);
    @(posedge clk);
    #1;
    ld_release();
    cpu_req = 1'b0;
    idle(4);
    check_eq("t1_prog_start_pulses", ps_count, 32'd1);

    // Test 2: loader writes 0x00..0x3F then reads back in one tenure.
    ps0 = ps_count;
    for (int i = 0; i < 64; i++) ld_xfer(1'b1, 16'(i), 8'(i) ^ 8'hA5, 8'h00, w);
    for (int i = 0; i < 64; i++) ld_xfer(1'b0, 16'(i), 8'h00, 8'(i) ^ 8'hA5, w);
    ld_release();
    idle(4);
    check_eq("t2_prog_start_pulses", ps_count - ps0, 32'd1);
    check_eq("t2_ld_queue_drained", ld_q.size(), 32'd0);

    // Test 3: sustained contention; 1 idle cycle then 8 LD / 8 CPU alternation.
    ld_req   = 1'b1;
    ld_we    = 1'b0;
    ld_addr  = 16'h0005;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0006;
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      exp_ld  = (c >= 1) && ((((c - 1) / 8) % 2) == 0);
      exp_cpu = (c >= 1) && !exp_ld;
      check_eq("t3_ld_gnt", {31'd0, ld_gnt}, {31'd0, exp_ld});
      check_eq("t3_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, exp_cpu});
      if (ld_gnt) ld_q.push_back(8'hA0);
      if (cpu_gnt) cpu_q.push_back(8'hA3);
      @(posedge clk);
      #1;
    end
    ld_release();
    cpu_req = 1'b0;
    idle(4);
    check_eq("t3_queues_drained", ld_q.size() + cpu_q.size(), 32'd0);

    // Test 4: CPU read of 0x0200 granted in the cycle ld_req rises.
    ld_xfer(1'b1, 16'h0200, 8'h3C, 8'h00, w);
    ld_release();
    idle(4);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0200;
    @(posedge clk);
    #1;
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 16'h0300;
    ld_wdata = 8'h77;
    @(negedge clk);
    check_eq("t4_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_eq("t4_ld_gnt_blocked", {31'd0, ld_gnt}, 32'd0);
    if (cpu_gnt) cpu_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("t4_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check_eq("t4_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    ld_xfer(1'b1, 16'h0300, 8'h77, 8'h00, w);
    check_eq("t4_ld_gnt_wait", w, 32'd0);
    ld_xfer(1'b0, 16'h0300, 8'h00, 8'h77, w);
    ld_release();
    idle(4);
    check_eq("t4_queues_drained", ld_q.size() + cpu_q.size(), 32'd0);

    // Test 5: reset in the middle of a loader write burst.
    for (int i = 0; i < 4; i++) ld_xfer(1'b1, 16'h0400 + 16'(i), 8'hEE, 8'h00, w);
    ld_release();
    idle(4);
    ps0 = ps_count;
    for (int i = 0; i < 3; i++) ld_xfer(1'b1, 16'h0400 + 16'(i), 8'h10 + 8'(i), 8'h00, w);
    ld_addr  = 16'h0403;
    ld_wdata = 8'h13;
    @(negedge clk);
    check_eq("t5_4th_write_granted", {31'd0, mem_we}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("t5_mem_we_drop", {31'd0, mem_we}, 32'd0);
    check_eq("t5_ld_gnt_drop", {31'd0, ld_gnt}, 32'd0);
    @(posedge clk);
    #1;
    ld_release();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    check_eq("t5_no_prog_start", ps_count - ps0, 32'd0);

    // Test 6: read-only tenure confirms persisted writes and raises no prog_start.
    ps0 = ps_count;
    ld_xfer(1'b0, 16'h0400, 8'h00, 8'h10, w);
    ld_xfer(1'b0, 16'h0401, 8'h00, 8'h11, w);
    ld_xfer(1'b0, 16'h0402, 8'h00, 8'h12, w);
    ld_xfer(1'b0, 16'h0403, 8'h00, 8'hEE, w);
    ld_release();
    idle(4);
    check_eq("t6_no_prog_start", ps_count - ps0, 32'd0);
    check_eq("t6_queues_drained", ld_q.size() + cpu_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
